dcache_refill_ctrl: RTL and testbench

- Miss-handling controller between the data cache and block-wide data memory in the MEM stage.
- On a load/store miss it stalls the pipeline and writes back a dirty victim block if one exists.
- It then fetches the missing 4-word block, buffers it and hands it to the cache for installation.
- It replaces the single-cycle combinational miss path with a multi-cycle, latency-tolerant sequence.

---
 rtl/dcache_refill_ctrl.sv | 134 +++++++++++++
 tb/tb_dcache_refill_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_refill_ctrl.sv
// Data-cache miss controller: optional dirty-victim write-back, block fetch from
// multi-cycle data memory, then a one-cycle refill handoff to the cache.
module dcache_refill_ctrl #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned BLOCK_WORDS = 4,
   parameter int unsigned MEM_LATENCY = 2
) (
   input  logic                              i_clk,
   input  logic                              i_rst,
   input  logic                              i_req_valid,
   input  logic                              i_hit,
   input  logic                              i_victim_dirty,
   input  logic [DATA_WIDTH-1:0]             i_miss_addr,
   input  logic [DATA_WIDTH-1:0]             i_victim_addr,
   input  logic [BLOCK_WORDS*DATA_WIDTH-1:0] i_victim_data,
   input  logic [BLOCK_WORDS*DATA_WIDTH-1:0] i_mem_rdata,
   output logic                              o_stall,
   output logic                              o_mem_wr_en,
   output logic                              o_mem_rd_en,
   output logic [DATA_WIDTH-1:0]             o_mem_addr,
   output logic [BLOCK_WORDS*DATA_WIDTH-1:0] o_mem_wdata,
   output logic                              o_refill_valid,
   output logic [BLOCK_WORDS*DATA_WIDTH-1:0] o_fill_data,
   output logic [31:0]                       o_miss_count,
   output logic [31:0]                       o_wb_count
);

   localparam int unsigned BLK_W    = BLOCK_WORDS * DATA_WIDTH;
   localparam int unsigned OFF_BITS = $clog2(BLOCK_WORDS * 4);
   localparam int unsigned CNT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam logic [CNT_W-1:0]      CNT_LOAD   = CNT_W'(MEM_LATENCY - 1);
   localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = {{(DATA_WIDTH - OFF_BITS){1'b1}},
                                                   {OFF_BITS{1'b0}}};

   typedef enum logic [1:0] {StIdle, StWriteback, StFetch, StRefill} state_t;

   state_t                r_state;
   state_t                w_state_d;
   logic [CNT_W-1:0]      r_cnt;
   logic [CNT_W-1:0]      w_cnt_d;
   logic [DATA_WIDTH-1:0] r_miss_addr;
   logic [DATA_WIDTH-1:0] r_victim_addr;
   logic [BLK_W-1:0]      r_victim_data;
   logic [BLK_W-1:0]      r_fill_data;
   logic [31:0]           r_miss_count;
   logic [31:0]           r_wb_count;
   logic                  w_miss;
   logic                  w_latch;
   logic                  w_fill_ld;

   assign w_miss = i_req_valid & ~i_hit;

   always_comb begin
      w_state_d      = r_state;
      w_cnt_d        = r_cnt;
      w_latch        = 1'b0;
      w_fill_ld      = 1'b0;
      o_stall        = 1'b0;
      o_mem_wr_en    = 1'b0;
      o_mem_rd_en    = 1'b0;
      o_mem_addr     = '0;
      o_mem_wdata    = '0;
      o_refill_valid = 1'b0;
      case (r_state)
         StIdle: begin
            // Combinational so the missing access freezes in its own cycle.
            o_stall = w_miss & ~i_rst;
            if (w_miss) begin
               w_latch   = 1'b1;
               w_cnt_d   = CNT_LOAD;
               w_state_d = i_victim_dirty ? StWriteback : StFetch;
            end
         end
         StWriteback: begin
            o_stall     = 1'b1;
            o_mem_addr  = r_victim_addr;
            o_mem_wdata = r_victim_data;
            o_mem_wr_en = (r_cnt == CNT_LOAD);
            if (r_cnt == '0) begin
               w_state_d = StFetch;
               w_cnt_d   = CNT_LOAD;
            end else begin
               w_cnt_d = r_cnt - 1'b1;
            end
         end
         StFetch: begin
            o_stall     = 1'b1;
            o_mem_rd_en = 1'b1;
            o_mem_addr  = r_miss_addr;
            if (r_cnt == '0) begin
               w_fill_ld = 1'b1;
               w_state_d = StRefill;
            end else begin
               w_cnt_d = r_cnt - 1'b1;
            end
         end
         StRefill: begin
            o_stall        = 1'b1;
            o_refill_valid = 1'b1;
            w_state_d      = StIdle;
         end
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state       <= StIdle;
         r_cnt         <= '0;
         r_miss_addr   <= '0;
         r_victim_addr <= '0;
         r_victim_data <= '0;
         r_fill_data   <= '0;
         r_miss_count  <= '0;
         r_wb_count    <= '0;
      end else begin
         r_state <= w_state_d;
         r_cnt   <= w_cnt_d;
         if (w_latch) begin
            r_miss_addr   <= i_miss_addr & ALIGN_MASK;
            r_victim_addr <= i_victim_addr & ALIGN_MASK;
            r_victim_data <= i_victim_data;
            if (r_miss_count != '1) r_miss_count <= r_miss_count + 32'd1;
            if (i_victim_dirty && r_wb_count != '1) r_wb_count <= r_wb_count + 32'd1;
         end
         if (w_fill_ld) r_fill_data <= i_mem_rdata;
      end
   end

   assign o_fill_data  = r_fill_data;
   assign o_miss_count = r_miss_count;
   assign o_wb_count   = r_wb_count;

endmodule

// File: tb/tb_dcache_refill_ctrl.sv
// Randomized bench for dcache_refill_ctrl; expected traces are expanded from the
// miss-sequence rules (write-back phase, fetch phase, refill pulse) per miss.
module tb_dcache_refill_ctrl;

   localparam int LAT = 2;
   localparam logic [31:0] MASK = 32'hFFFF_FFF0;

   logic         clk = 1'b0;
   logic         rst;
   logic         req_valid, hit, victim_dirty;
   logic [31:0]  miss_addr, victim_addr;
   logic [127:0] victim_data, mem_rdata;
   logic         stall, mem_wr_en, mem_rd_en, refill_valid;
   logic [31:0]  mem_addr, miss_count, wb_count;
   logic [127:0] mem_wdata, fill_data;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          cycle   = 0;
   logic [31:0] exp_miss = 0;
   logic [31:0] exp_wb   = 0;

   dcache_refill_ctrl #(
      .DATA_WIDTH (32),
      .BLOCK_WORDS(4),
      .MEM_LATENCY(LAT)
   ) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_req_valid   (req_valid),
      .i_hit         (hit),
      .i_victim_dirty(victim_dirty),
      .i_miss_addr   (miss_addr),
      .i_victim_addr (victim_addr),
      .i_victim_data (victim_data),
      .i_mem_rdata   (mem_rdata),
      .o_stall       (stall),
      .o_mem_wr_en   (mem_wr_en),
      .o_mem_rd_en   (mem_rd_en),
      .o_mem_addr    (mem_addr),
      .o_mem_wdata   (mem_wdata),
      .o_refill_valid(refill_valid),
      .o_fill_data   (fill_data),
      .o_miss_count  (miss_count),
      .o_wb_count    (wb_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   // One full miss: detect cycle, then [LAT write-back cycles], LAT fetch cycles, refill.
   task automatic exercise_miss(input logic [31:0] maddr, input logic [31:0] vaddr,
                                input logic [127:0] vdata, input logic [127:0] rdata,
                                input logic dirty, input bit check_idle,
                                output int refill_cyc);
      int         n_wb;
      logic [3:0] exp_ctl;
      @(negedge clk);
      req_valid = 1'b1; hit = 1'b0; victim_dirty = dirty;
      miss_addr = maddr; victim_addr = vaddr; victim_data = vdata; mem_rdata = rnd128();
      #1;
      n_tests++;
      if ({stall, mem_wr_en, mem_rd_en, refill_valid} !== 4'b1000) begin
         n_fail++;
         $display("FAIL miss_detect: got %b expected 1000", {stall, mem_wr_en, mem_rd_en,
                  refill_valid});
      end
      exp_miss = sat_inc(exp_miss);
      if (dirty) exp_wb = sat_inc(exp_wb);
      n_wb = dirty ? LAT : 0;
      refill_cyc = -1;
      for (int c = 0; c < n_wb + LAT + 1; c++) begin
         @(negedge clk);
         // Inputs outside IDLE must be ignored, so scramble them.
         req_valid = 1'($urandom); hit = 1'($urandom); victim_dirty = 1'($urandom);
         miss_addr = $urandom; victim_addr = $urandom; victim_data = rnd128();
         mem_rdata = (c == n_wb + LAT - 1) ? rdata : rnd128();
         #1;
         if (c < n_wb)            exp_ctl = {1'b1, (c == 0), 1'b0, 1'b0};
         else if (c < n_wb + LAT) exp_ctl = 4'b1010;
         else                     exp_ctl = 4'b1001;
         n_tests++;
         if ({stall, mem_wr_en, mem_rd_en, refill_valid} !== exp_ctl) begin
            n_fail++;
            $display("FAIL ctl_cycle%0d: got %b expected %b", c,
                     {stall, mem_wr_en, mem_rd_en, refill_valid}, exp_ctl);
         end
         if (c < n_wb) begin
            n_tests++;
            if (mem_addr !== (vaddr & MASK) || mem_wdata !== vdata) begin
               n_fail++;
               $display("FAIL wb_addr_data: got %h/%h expected %h/%h", mem_addr, mem_wdata,
                        vaddr & MASK, vdata);
            end
         end else if (c < n_wb + LAT) begin
            n_tests++;
            if (mem_addr !== (maddr & MASK)) begin
               n_fail++;
               $display("FAIL fetch_addr: got %h expected %h", mem_addr, maddr & MASK);
            end
         end else begin
            refill_cyc = cycle;
            n_tests++;
            if (fill_data !== rdata) begin
               n_fail++;
               $display("FAIL fill_data: got %h expected %h", fill_data, rdata);
            end
            n_tests++;
            if (miss_count !== exp_miss || wb_count !== exp_wb) begin
               n_fail++;
               $display("FAIL counters: got %h/%h expected %h/%h", miss_count, wb_count,
                        exp_miss, exp_wb);
            end
         end
      end
      if (check_idle) begin
         @(negedge clk);
         req_valid = 1'b1; hit = 1'b1; miss_addr = maddr;
         #1;
         n_tests++;
         if ({stall, mem_wr_en, mem_rd_en, refill_valid} !== 4'b0000) begin
            n_fail++;
            $display("FAIL after_refill_hit: got %b expected 0000",
                     {stall, mem_wr_en, mem_rd_en, refill_valid});
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = 1'b1; hit = 1'b0; victim_dirty = 1'b1;
      miss_addr = 32'h1234; victim_addr = 32'h40; victim_data = rnd128(); mem_rdata = rnd128();
      #1;
      n_tests++;
      if ({stall, mem_wr_en, mem_rd_en, refill_valid} !== 4'b0000 || mem_addr !== 32'h0 ||
          mem_wdata !== 128'h0 || fill_data !== 128'h0 || miss_count !== 32'h0 ||
          wb_count !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_state: got ctl=%b addr=%h cnt=%h/%h", {stall, mem_wr_en,
                  mem_rd_en, refill_valid}, mem_addr, miss_count, wb_count);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0; rst = 1'b0;
   endtask

   task automatic test_hit_stream();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         req_valid = 1'b1; hit = 1'b1; victim_dirty = 1'($urandom); miss_addr = $urandom;
         #1;
         n_tests++;
         if ({stall, mem_wr_en, mem_rd_en, refill_valid} !== 4'b0000 ||
             miss_count !== 32'h0 || wb_count !== 32'h0) begin
            n_fail++;
            $display("FAIL hit_stream: got ctl=%b cnt=%h/%h expected 0000 0/0",
                     {stall, mem_wr_en, mem_rd_en, refill_valid}, miss_count, wb_count);
         end
      end
   endtask

   task automatic test_clean_miss();
      int r;
      exercise_miss(32'h0000_1234, 32'h0000_0500, rnd128(),
                    128'hDDDD_DDDD_CCCC_CCCC_BBBB_BBBB_AAAA_AAAA, 1'b0, 1'b1, r);
   endtask

   task automatic test_dirty_miss();
      int r;
      exercise_miss(32'h0000_0084, 32'h0000_0040, rnd128(), rnd128(), 1'b1, 1'b1, r);
   endtask

   task automatic test_reset_mid_fetch();
      int r;
      @(negedge clk);
      req_valid = 1'b1; hit = 1'b0; victim_dirty = 1'b0; miss_addr = 32'h0000_0700;
      @(negedge clk);
      req_valid = 1'b0;
      @(posedge clk);  // now in the second fetch cycle
      #2 rst = 1'b1;
      #1;
      n_tests++;
      if ({stall, mem_wr_en, mem_rd_en, refill_valid} !== 4'b0000 || mem_addr !== 32'h0 ||
          fill_data !== 128'h0 || miss_count !== 32'h0 || wb_count !== 32'h0) begin
         n_fail++;
         $display("FAIL async_reset: got ctl=%b addr=%h cnt=%h/%h expected all zero",
                  {stall, mem_wr_en, mem_rd_en, refill_valid}, mem_addr, miss_count, wb_count);
      end
      exp_miss = 0; exp_wb = 0;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         n_tests++;
         if ({stall, mem_wr_en, mem_rd_en, refill_valid} !== 4'b0000) begin
            n_fail++;
            $display("FAIL post_reset_quiet: got %b expected 0000",
                     {stall, mem_wr_en, mem_rd_en, refill_valid});
         end
      end
      exercise_miss(32'h0000_0ABC, 32'h0, rnd128(), rnd128(), 1'b0, 1'b1, r);
   endtask

   task automatic test_back_to_back();
      int r1, r2;
      exercise_miss(32'h0000_0100, 32'h0000_0900, rnd128(), rnd128(), 1'b0, 1'b0, r1);
      exercise_miss(32'h0000_0200, 32'h0000_0A00, rnd128(), rnd128(), 1'b0, 1'b1, r2);
      n_tests++;
      if (r2 - r1 - 1 != LAT + 1) begin
         n_fail++;
         $display("FAIL refill_gap: got %0d expected %0d", r2 - r1 - 1, LAT + 1);
      end
   endtask

   task automatic test_random_misses();
      int r;
      for (int i = 0; i < 8; i++) begin
         exercise_miss($urandom, $urandom, rnd128(), rnd128(), 1'($urandom), 1'($urandom), r);
      end
   endtask

   task automatic test_saturation();
      int r;
      @(negedge clk);
      req_valid = 1'b0;
      force dut.r_miss_count = 32'hFFFF_FFFE;
      force dut.r_wb_count   = 32'hFFFF_FFFE;
      #1;
      release dut.r_miss_count;
      release dut.r_wb_count;
      exp_miss = 32'hFFFF_FFFE; exp_wb = 32'hFFFF_FFFE;
      for (int i = 0; i < 3; i++) begin
         exercise_miss($urandom, $urandom, rnd128(), rnd128(), 1'b1, 1'b1, r);
      end
      n_tests++;
      if (miss_count !== 32'hFFFF_FFFF || wb_count !== 32'hFFFF_FFFF) begin
         n_fail++;
         $display("FAIL saturation: got %h/%h expected ffffffff/ffffffff", miss_count,
                  wb_count);
      end
   endtask

   initial begin
      test_reset();
      test_hit_stream();
      test_clean_miss();
      test_dirty_miss();
      test_reset_mid_fetch();
      test_back_to_back();
      test_random_misses();
      test_saturation();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

endmodule
